// File: rtl/snake_pkg.sv
// Shared constants for the snake game blocks: sequencer state encoding and grid geometry.
package snake_pkg;

  localparam logic [1:0] MSM_IDLE = 2'd0;
  localparam logic [1:0] MSM_PLAY = 2'd1;
  localparam logic [1:0] MSM_WIN  = 2'd2;
  localparam logic [1:0] MSM_LOSE = 2'd3;

  localparam int GRID_X_W = 8;
  localparam int GRID_Y_W = 7;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for a raw asynchronous input, followed by a registered rising-edge pulse.
module sync_edge_detect (
  input  logic CLK,
  input  logic RESET,
  input  logic D,
  output logic PULSE
);

  logic s1;
  logic s2;
  logic s2_q;

  // PULSE is registered so an input high at edge n yields a pulse during cycle n+2.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s2_q  <= 1'b0;
      PULSE <= 1'b0;
    end else begin
      s1    <= D;
      s2    <= s1;
      s2_q  <= s2;
      PULSE <= s2 & ~s2_q;
    end
  end

endmodule

// File: rtl/master_state_machine.sv
// Snake game sequencer: IDLE/PLAY/WIN/LOSE state, movement tick generation, score and new-target requests.
module master_state_machine
  import snake_pkg::*;
#(
  parameter int TICK_DIV  = 10_000_000,
  parameter int WIN_SCORE = 10,
  parameter int SCORE_W   = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               BTN_U,
  input  logic               BTN_D,
  input  logic               BTN_L,
  input  logic               BTN_R,
  input  logic               TARGET_REACHED,
  input  logic               COLLISION,
  output logic [1:0]         MSM_STATE,
  output logic               GAME_TICK,
  output logic               NEW_TARGET,
  output logic [SCORE_W-1:0] SCORE
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(TICK_DIV - 1);
  localparam logic [SCORE_W-1:0] SCORE_LAST = SCORE_W'(WIN_SCORE - 1);

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [CNT_W-1:0] tick_cnt;
  logic             evt_u, evt_d, evt_l, evt_r;
  logic             btn_evt;
  logic             tr_q;
  logic             tr_evt;
  logic             score_clr;
  logic             score_inc;
  logic             target_req;
  logic             tick_run;

  sync_edge_detect u_sync_u (.CLK(CLK), .RESET(RESET), .D(BTN_U), .PULSE(evt_u));
  sync_edge_detect u_sync_d (.CLK(CLK), .RESET(RESET), .D(BTN_D), .PULSE(evt_d));
  sync_edge_detect u_sync_l (.CLK(CLK), .RESET(RESET), .D(BTN_L), .PULSE(evt_l));
  sync_edge_detect u_sync_r (.CLK(CLK), .RESET(RESET), .D(BTN_R), .PULSE(evt_r));

  assign btn_evt   = evt_u | evt_d | evt_l | evt_r;
  assign tr_evt    = TARGET_REACHED & ~tr_q;
  assign MSM_STATE = state;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= MSM_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Collision outranks a simultaneous target hit; events outside their state are dropped.
  always_comb begin
    next_state = state;
    case (state)
      MSM_IDLE: if (btn_evt) next_state = MSM_PLAY;
      MSM_PLAY: begin
        if (COLLISION) begin
          next_state = MSM_LOSE;
        end else if (tr_evt && (SCORE == SCORE_LAST)) begin
          next_state = MSM_WIN;
        end
      end
      MSM_WIN:  if (btn_evt) next_state = MSM_IDLE;
      MSM_LOSE: if (btn_evt) next_state = MSM_IDLE;
      default:  next_state = MSM_IDLE;
    endcase
  end

  always_comb begin
    score_clr  = (state == MSM_IDLE) && btn_evt;
    score_inc  = (state == MSM_PLAY) && !COLLISION && tr_evt;
    target_req = score_inc && (SCORE != SCORE_LAST);
    tick_run   = (state == MSM_PLAY) && (next_state == MSM_PLAY);
  end

  // The tick only runs while staying in PLAY, so a tick never lands after leaving it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tr_q       <= 1'b0;
      SCORE      <= '0;
      NEW_TARGET <= 1'b0;
      tick_cnt   <= '0;
      GAME_TICK  <= 1'b0;
    end else begin
      tr_q       <= TARGET_REACHED;
      NEW_TARGET <= target_req;
      if (score_clr) begin
        SCORE <= '0;
      end else if (score_inc) begin
        SCORE <= SCORE + SCORE_W'(1);
      end
      if (tick_run) begin
        if (tick_cnt == CNT_MAX) begin
          tick_cnt  <= '0;
          GAME_TICK <= 1'b1;
        end else begin
          tick_cnt  <= tick_cnt + CNT_W'(1);
          GAME_TICK <= 1'b0;
        end
      end else begin
        tick_cnt  <= '0;
        GAME_TICK <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_master_state_machine.sv
// Self-checking bench for master_state_machine with TICK_DIV=4, WIN_SCORE=3.
module tb_master_state_machine;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_WIN  = 2'd2;
  localparam logic [1:0] S_LOSE = 2'd3;
  localparam int TDIV = 4;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       BTN_U = 1'b0, BTN_D = 1'b0, BTN_L = 1'b0, BTN_R = 1'b0;
  logic       TARGET_REACHED = 1'b0;
  logic       COLLISION = 1'b0;
  logic [1:0] MSM_STATE;
  logic       GAME_TICK;
  logic       NEW_TARGET;
  logic [3:0] SCORE;

  int n_checks = 0;
  int n_errors = 0;
  int pc = 0;
  logic [1:0] prev_st = S_IDLE;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  master_state_machine #(.TICK_DIV(4), .WIN_SCORE(3), .SCORE_W(4)) dut (
    .CLK(clk), .RESET(RESET),
    .BTN_U(BTN_U), .BTN_D(BTN_D), .BTN_L(BTN_L), .BTN_R(BTN_R),
    .TARGET_REACHED(TARGET_REACHED), .COLLISION(COLLISION),
    .MSM_STATE(MSM_STATE), .GAME_TICK(GAME_TICK), .NEW_TARGET(NEW_TARGET), .SCORE(SCORE)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  // Drives one cycle of inputs and queues the outputs expected after the next edge.
  // The expected tick comes from cycles spent in PLAY since entry: every TDIV-th one.
  task automatic cyc(input logic rst, input logic [3:0] btn, input logic tr, input logic col,
                     input logic [1:0] est, input logic [3:0] esc, input logic ent);
    logic etick;
    @(negedge clk);
    RESET = rst;
    {BTN_U, BTN_D, BTN_L, BTN_R} = btn;
    TARGET_REACHED = tr;
    COLLISION = col;
    if (est == S_PLAY && prev_st == S_PLAY) begin
      pc++;
      etick = ((pc % TDIV) == 0);
    end else begin
      pc = 0;
      etick = 1'b0;
    end
    prev_st = est;
    exp_q.push_back({est, etick, ent, esc});
  endtask

  // One-cycle button press: the state moves on the third edge after it is sampled.
  task automatic press(input logic [3:0] btn, input logic [1:0] cur, input logic [1:0] nxt,
                       input logic [3:0] sc_cur, input logic [3:0] sc_nxt);
    cyc(1'b0, btn, 1'b0, 1'b0, cur, sc_cur, 1'b0);
    cyc(1'b0, 4'b0, 1'b0, 1'b0, cur, sc_cur, 1'b0);
    cyc(1'b0, 4'b0, 1'b0, 1'b0, cur, sc_cur, 1'b0);
    cyc(1'b0, 4'b0, 1'b0, 1'b0, nxt, sc_nxt, 1'b0);
  endtask

  always @(posedge clk) begin
    logic [7:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("state", 32'(MSM_STATE), 32'(e[7:6]));
      chk("game_tick", 32'(GAME_TICK), 32'(e[5]));
      chk("new_target", 32'(NEW_TARGET), 32'(e[4]));
      chk("score", 32'(SCORE), 32'(e[3:0]));
    end
  end

  initial begin
    // Reset, then a held button gives exactly one IDLE->PLAY transition.
    cyc(1'b1, 4'b0, 1'b0, 1'b0, S_IDLE, 4'd0, 1'b0);
    cyc(1'b1, 4'b0, 1'b0, 1'b0, S_IDLE, 4'd0, 1'b0);
    cyc(1'b0, 4'b0, 1'b0, 1'b0, S_IDLE, 4'd0, 1'b0);
    for (int j = 0; j < 10; j++)
      cyc(1'b0, 4'b1000, 1'b0, 1'b0, (j >= 3) ? S_PLAY : S_IDLE, 4'd0, 1'b0);
    for (int j = 0; j < 6; j++)
      cyc(1'b0, 4'b0, 1'b0, 1'b0, S_PLAY, 4'd0, 1'b0);

    // Held target gives one score and one NEW_TARGET; third score wins without a request.
    cyc(1'b0, 4'b0, 1'b1, 1'b0, S_PLAY, 4'd1, 1'b1);
    for (int j = 0; j < 4; j++)
      cyc(1'b0, 4'b0, 1'b1, 1'b0, S_PLAY, 4'd1, 1'b0);
    cyc(1'b0, 4'b0, 1'b0, 1'b0, S_PLAY, 4'd1, 1'b0);
    cyc(1'b0, 4'b0, 1'b1, 1'b0, S_PLAY, 4'd2, 1'b1);
    cyc(1'b0, 4'b0, 1'b0, 1'b0, S_PLAY, 4'd2, 1'b0);
    cyc(1'b0, 4'b0, 1'b1, 1'b0, S_WIN, 4'd3, 1'b0);
    cyc(1'b0, 4'b0, 1'b0, 1'b0, S_WIN, 4'd3, 1'b0);
    cyc(1'b0, 4'b0, 1'b1, 1'b0, S_WIN, 4'd3, 1'b0);
    cyc(1'b0, 4'b0, 1'b0, 1'b1, S_WIN, 4'd3, 1'b0);
    for (int j = 0; j < 5; j++)
      cyc(1'b0, 4'b0, 1'b0, 1'b0, S_WIN, 4'd3, 1'b0);

    // WIN -> IDLE keeps the score, IDLE -> PLAY clears it.
    press(4'b0100, S_WIN, S_IDLE, 4'd3, 4'd3);
    press(4'b0001, S_IDLE, S_PLAY, 4'd3, 4'd0);

    // Collision beats a simultaneous target hit.
    cyc(1'b0, 4'b0, 1'b1, 1'b0, S_PLAY, 4'd1, 1'b1);
    cyc(1'b0, 4'b0, 1'b0, 1'b0, S_PLAY, 4'd1, 1'b0);
    cyc(1'b0, 4'b0, 1'b1, 1'b1, S_LOSE, 4'd1, 1'b0);
    cyc(1'b0, 4'b0, 1'b0, 1'b0, S_LOSE, 4'd1, 1'b0);

    // A held button in LOSE reaches IDLE only; target and collision ignored in IDLE.
    for (int j = 0; j < 6; j++)
      cyc(1'b0, 4'b0010, 1'b0, 1'b0, (j >= 3) ? S_IDLE : S_LOSE, 4'd1, 1'b0);
    cyc(1'b0, 4'b0, 1'b0, 1'b0, S_IDLE, 4'd1, 1'b0);
    cyc(1'b0, 4'b0, 1'b1, 1'b0, S_IDLE, 4'd1, 1'b0);
    cyc(1'b0, 4'b0, 1'b0, 1'b0, S_IDLE, 4'd1, 1'b0);
    cyc(1'b0, 4'b0, 1'b0, 1'b1, S_IDLE, 4'd1, 1'b0);
    press(4'b0001, S_IDLE, S_PLAY, 4'd1, 4'd0);

    // Buttons are ignored in PLAY; then reach score 2.
    press(4'b1000, S_PLAY, S_PLAY, 4'd0, 4'd0);
    cyc(1'b0, 4'b0, 1'b1, 1'b0, S_PLAY, 4'd1, 1'b1);
    cyc(1'b0, 4'b0, 1'b0, 1'b0, S_PLAY, 4'd1, 1'b0);
    cyc(1'b0, 4'b0, 1'b1, 1'b0, S_PLAY, 4'd2, 1'b1);
    cyc(1'b0, 4'b0, 1'b0, 1'b0, S_PLAY, 4'd2, 1'b0);

    // Reset lands on the edge where a tick is due.
    for (int j = 0; j < TDIV && ((pc + 1) % TDIV) != 0; j++)
      cyc(1'b0, 4'b0, 1'b0, 1'b0, S_PLAY, 4'd2, 1'b0);
    cyc(1'b1, 4'b0, 1'b0, 1'b0, S_IDLE, 4'd0, 1'b0);
    cyc(1'b0, 4'b0, 1'b0, 1'b0, S_IDLE, 4'd0, 1'b0);
    cyc(1'b0, 4'b0, 1'b0, 1'b0, S_IDLE, 4'd0, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
